// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and its helpers.
//   state_t     : responder FSM encoding (IDLE/WAIT/RESP)
//   WORD_BYTES  : bytes per memory word (drives alignment check)
//   ERR_SAT     : saturation value of the error counter
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [7:0]  ERR_SAT    = 8'hFF;

endpackage

// File: rtl/dmem_responder_lat_counter.sv
// Loadable down-counter used to model a fixed access latency.
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset (clears count)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one, holding at zero
//   count    : current count
//   done     : count has drained to zero
module dmem_lat_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store port. Accepts one word
// request at a time, models a fixed access latency, returns read data or a
// write completion, and freezes the pipeline while the access is pending.
//   clk, reset            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store, 0 = load
//   req_addr, req_wdata   : byte address (word index = addr[31:2]), store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata, resp_err  : load data (0 for stores/errors), error flag
//   stall                 : pipeline freeze request
//   err_count             : saturating count of errored requests
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [7:0]  err_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OFF_W = $clog2(WORD_BYTES);

  state_t state, next_state;

  logic accept, enter_resp, resp_done, cnt_done;
  logic [CNT_W-1:0] cnt_value;

  logic             req_mis, req_oor;
  logic             lat_write, lat_err;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;

  logic             cur_write, cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_wdata;

  logic [31:0] mem [DEPTH];

  assign req_mis = (req_addr[OFF_W-1:0] != '0);
  assign req_oor = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  dmem_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (state == WAIT),
    .count    (cnt_value),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    resp_done  = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        // The counter is loaded with LATENCY-1 and drains one per WAIT
        // cycle, so reaching zero lands the response on edge T+LATENCY.
        if (cnt_done) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY==1 the commit happens on the accept edge itself, so the
  // live request fields are used instead of the latched copies.
  always_comb begin
    if (state == IDLE) begin
      cur_write = req_write;
      cur_idx   = req_addr[OFF_W +: IDX_W];
      cur_wdata = req_wdata;
      cur_err   = req_mis | req_oor;
    end else begin
      cur_write = lat_write;
      cur_idx   = lat_idx;
      cur_wdata = lat_wdata;
      cur_err   = lat_err;
    end
  end

  // Gated by reset so a pending access does not freeze the pipeline while
  // reset is being applied.
  assign stall = reset && ((state != IDLE) || (req_valid && !req_ready));

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
      lat_write  <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= 32'(i);
      end
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_idx   <= req_addr[OFF_W +: IDX_W];
        lat_wdata <= req_wdata;
        lat_err   <= req_mis | req_oor;
      end
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_rdata <= '0;
        if (cur_err) begin
          if (err_count != ERR_SAT) err_count <= err_count + 8'd1;
        end else if (cur_write) begin
          mem[cur_idx] <= cur_wdata;
        end else begin
          resp_rdata <= mem[cur_idx];
        end
      end else if (resp_done) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  dmem_responder #(
    .DEPTH   (128),
    .LATENCY (2),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response is compared with the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] er;
    logic        ee;
    if (reset && resp_valid && resp_ready) begin
      if (exp_rdata_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b with no request outstanding", resp_rdata, resp_err);
      end else begin
        er = exp_rdata_q.pop_front();
        ee = exp_err_q.pop_front();
        check32("resp_rdata", resp_rdata, er);
        check32("resp_err", {31'b0, resp_err}, {31'b0, ee});
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_er);
    int n = 0;
    logic rdy;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    rdy = req_ready;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = req_ready;
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: got req_ready 0 expected 1 within 100 cycles");
    end else begin
      exp_rdata_q.push_back(exp_rd);
      exp_err_q.push_back(exp_er);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_rdata_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32("drain_outstanding", exp_rdata_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_resp_valid", {31'b0, resp_valid}, 0);
    check32("rst_resp_rdata", resp_rdata, 0);
    check32("rst_err_count", {24'b0, err_count}, 0);
    check32("rst_stall", {31'b0, stall}, 0);
    check32("rst_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load 0x14 with cycle-accurate latency and stall profile
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0014; req_wdata = '0;
    check32("t1_req_ready", {31'b0, req_ready}, 1);
    exp_rdata_q.push_back(32'd5);
    exp_err_q.push_back(1'b0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check32("t1_valid_T0", {31'b0, resp_valid}, 0);
    check32("t1_stall_T0", {31'b0, stall}, 1);
    @(negedge clk);
    check32("t1_valid_T1", {31'b0, resp_valid}, 0);
    check32("t1_stall_T1", {31'b0, stall}, 1);
    @(negedge clk);
    check32("t1_valid_T2", {31'b0, resp_valid}, 1);
    check32("t1_stall_T2", {31'b0, stall}, 1);
    @(negedge clk);
    check32("t1_stall_T3", {31'b0, stall}, 0);
    check32("t1_valid_T3", {31'b0, resp_valid}, 0);

    // Store then load back
    do_req(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Error cases: misaligned and out-of-range, loads and stores
    do_req(1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h0000_0200, 32'h0, 32'h0, 1'b1);
    drain();
    check32("t3_err_count2", {24'b0, err_count}, 2);
    do_req(1'b1, 32'h0000_01FE, 32'h1234_5678, 32'h0, 1'b1);
    do_req(1'b1, 32'h0000_0200, 32'h0000_0055, 32'h0, 1'b1);
    do_req(1'b0, 32'h0000_0010, 32'h0, 32'd4, 1'b0);
    do_req(1'b0, 32'h0000_01FC, 32'h0, 32'd127, 1'b0);
    do_req(1'b0, 32'h0000_0000, 32'h0, 32'd0, 1'b0);
    drain();
    check32("t3_err_count4", {24'b0, err_count}, 4);

    // Response back-pressure
    resp_ready = 1'b0;
    do_req(1'b0, 32'h0000_000C, 32'h0, 32'd3, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check32("bp_resp_valid", {31'b0, resp_valid}, 1);
      check32("bp_resp_rdata", resp_rdata, 3);
      check32("bp_req_ready", {31'b0, req_ready}, 0);
      check32("bp_stall", {31'b0, stall}, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check32("bp_still_valid", {31'b0, resp_valid}, 1);
    @(negedge clk);
    check32("bp_idle_ready", {31'b0, req_ready}, 1);
    check32("bp_idle_stall", {31'b0, stall}, 0);
    check32("bp_idle_valid", {31'b0, resp_valid}, 0);

    // Reset while a store sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0008; req_wdata = 32'hAAAA_5555;
    check32("t5_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check32("t5_stall_in_reset", {31'b0, stall}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check32("t5_no_response", {31'b0, seen}, 0);
    check32("t5_err_count_cleared", {24'b0, err_count}, 0);
    do_req(1'b0, 32'h0000_0008, 32'h0, 32'd2, 1'b0);
    do_req(1'b0, 32'h0000_0020, 32'h0, 32'd8, 1'b0);
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      do_req(1'b0, (i % 2 == 0) ? 32'h0000_0201 : 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
    end
    drain();
    check32("t6_err_sat", {24'b0, err_count}, 255);
    do_req(1'b0, 32'h0000_0014, 32'h0, 32'd5, 1'b0);
    drain();
    check32("t6_err_hold", {24'b0, err_count}, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
